// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX FIFO write port among byte-stream clients.
// Ownership lasts for a whole message (ended by req_last). An owner that stays idle
// too long mid-message is evicted, which raises a one-cycle error pulse.
module uart_tx_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned IDLE_TIMEOUT = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          req_valid,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   req_data,
    input  logic [NUM_CLIENTS-1:0]          req_last,
    output logic [NUM_CLIENTS-1:0]          req_ready,
    output logic [DATA_W-1:0]               w_data,
    output logic                            wr_uart,
    input  logic                            tx_full,
    output logic [$clog2(NUM_CLIENTS)-1:0]  grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [$clog2(NUM_CLIENTS)-1:0]  timeout_id
);

    localparam int unsigned ID_W     = $clog2(NUM_CLIENTS);
    localparam int unsigned CNT_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned TO_LAST  = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    grant_d;
    logic [ID_W-1:0]    rr_ptr, rr_d;
    logic [CNT_W-1:0]   idle_cnt, cnt_d;
    logic               terr_d;
    logic [ID_W-1:0]    tid_d;
    logic [ID_W-1:0]    grant_nxt;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic               xfer;
    logic [DATA_W-1:0]  data_arr [NUM_CLIENTS];

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant_id    <= '0;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state       <= state_d;
            grant_id    <= grant_d;
            rr_ptr      <= rr_d;
            idle_cnt    <= cnt_d;
            timeout_err <= terr_d;
            timeout_id  <= tid_d;
        end
    end

    // Split the flat request bus into per-client bytes
    always_comb begin
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            data_arr[i] = req_data[i*int'(DATA_W) +: DATA_W];
        end
    end

    // Round-robin pick: first valid requester at or above rr_ptr, with wrap
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_CLIENTS;
            if (!pick_found && req_valid[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Owner after the current one, used to demote a finished or evicted client
    always_comb begin
        grant_nxt = (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + ID_W'(1);
    end

    // Next-state logic: arbitration, end of message, idle-timeout eviction
    always_comb begin
        state_d = state;
        grant_d = grant_id;
        rr_d    = rr_ptr;
        cnt_d   = idle_cnt;
        terr_d  = 1'b0;
        tid_d   = timeout_id;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_OWN;
                    grant_d = pick_id;
                    cnt_d   = '0;
                end
            end
            S_OWN: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (req_last[grant_id]) begin
                        state_d = S_IDLE;
                        rr_d    = grant_nxt;
                    end
                end else if ((IDLE_TIMEOUT != 0) && !req_valid[grant_id]) begin
                    if (idle_cnt == CNT_W'(TO_LAST)) begin
                        terr_d  = 1'b1;
                        tid_d   = grant_id;
                        state_d = S_IDLE;
                        rr_d    = grant_nxt;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = idle_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte path to the FIFO: pass-through from the owner, no added latency
    always_comb begin
        req_ready = '0;
        wr_uart   = 1'b0;
        w_data    = '0;
        busy      = 1'b0;
        xfer      = 1'b0;
        if (!reset && state == S_OWN) begin
            busy                = 1'b1;
            req_ready[grant_id] = ~tx_full;
            xfer                = req_valid[grant_id] & ~tx_full;
            if (xfer) begin
                wr_uart = 1'b1;
                w_data  = data_arr[grant_id];
            end
        end
    end

endmodule
